regfile_sb: RTL and testbench
=============================

Name: regfile_sb

Overview:
Parametrised multi-read-port integer register file with a per-register busy/tag scoreboard, for the pipelined CPU core.
- Issue stage reserves a destination register with a producer tag.
- Writeback commits data only when its tag matches the newest reservation. This drops stale WAW writebacks.
- Read ports return bypassed data plus a busy flag, so decode can stall or forward without extra logic.
- x0 is hardwired to zero and is never busy.

Parameters:
XLEN, 32, data width of each register
NREG, 32, number of architectural registers (power of two, >=2)
AW, $clog2(NREG), register address width (derived; not overridden)
NRD, 2, number of read ports
TAGW, 4, producer tag width

Ports:
clk  in  1  global clock, all state updates on rising edge
rst  in  1  synchronous reset, active high
rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW]
rd_data  out  NRD*XLEN  read data per port, combinational
rd_busy  out  NRD  per-port: source register has an outstanding producer
rd_tag  out  NRD*TAGW  per-port: tag of the outstanding producer (valid when busy)
iss_en  in  1  reserve destination register
iss_addr  in  AW  destination register to reserve
iss_tag  in  TAGW  tag of the new producer
wb_en  in  1  writeback valid
wb_addr  in  AW  writeback register
wb_tag  in  TAGW  tag of the producer writing back
wb_data  in  XLEN  writeback data
flush  in  1  pipeline flush: drop all reservations

Behaviour:
- State: regs[NREG] (XLEN), busy[NREG] (1 bit), tag[NREG] (TAGW).
- Reset (rst=1 at posedge) clears all regs, busy and tag to 0. Output values after reset:
  - rd_data = 0
  - rd_busy = 0
  - rd_tag = 0
- rst has priority over every other input. Asserting it mid-operation discards all reservations and data.
- Tag match: wb_hit = wb_en & (wb_addr!=0) & busy[wb_addr] & (tag[wb_addr]==wb_tag).
- Writeback with wb_hit:
  - regs[wb_addr] <= wb_data;
  - busy[wb_addr] <= 0, unless it is overridden below.
- Writeback without wb_hit (stale tag, non-busy register, or x0) is ignored entirely: no data write, no busy change.
- Issue with iss_en & iss_addr!=0 & !flush:
  - busy[iss_addr] <= 1;
  - tag[iss_addr] <= iss_tag.
- Issue to x0 is ignored.
- Issue and writeback to the same register in the same cycle:
  - data is written if wb_hit;
  - busy ends at 1 and tag ends at iss_tag (issue wins).
- Issue to an already-busy register: the tag is overwritten. The older producer's later writeback misses and is dropped.
- flush=1:
  - every busy bit is 0 next cycle;
  - iss_en is ignored that cycle;
  - a wb_hit in the same cycle still writes data, evaluated against pre-flush state.
- Read port k, with a = rd_addr[k]:
  - a==0: rd_data=0, rd_busy=0, rd_tag=0.
  - else if wb_hit & wb_addr==a (same-cycle bypass): rd_data=wb_data, rd_busy=0.
  - else: rd_data=regs[a], rd_busy=busy[a], rd_tag=tag[a].
- Reads have zero latency and are purely combinational from the inputs and the current state.
- Read ports do not see a same-cycle issue. The busy bit from an issue appears the cycle after.
- No X propagation: out-of-range addresses cannot occur because NREG is a power of two.

Decomposition:
- Shared package (cpu_pkg): XLEN, NREG, AW, TAGW defaults, and a REG_ZERO constant (0).
- One natural sub-module: regfile_sb_rdport, a single read port with the bypass mux and x0 masking. It is instantiated NRD times in a generate loop.
- Scoreboard and storage stay in the top module.

Test Plan:
- Reset, then read x5 on both ports -> rd_data=0, rd_busy=0. Issue x0 tag 3 and read x0 -> busy=0, data=0.
- Issue x5 tag 2; next cycle read x5 -> busy=1, tag=2. wb x5 tag 2 data 0xDEADBEEF; same-cycle read -> data=0xDEADBEEF, busy=0. Next cycle -> regs[5]=0xDEADBEEF, busy=0.
- WAW: issue x7 tag 1, then issue x7 tag 4. wb x7 tag 1 data 0x11 -> ignored, busy=1, data unchanged. wb x7 tag 4 data 0x44 -> x7=0x44, busy=0.
- Simultaneous: x9 busy tag 3; same cycle wb x9 tag 3 data 0x99 and issue x9 tag 5 -> next cycle x9=0x99, busy=1, tag=5.
- Flush: issue x1, x2, x3 (tags 1, 2, 3); flush with issue x4 tag 6 and wb x2 tag 2 data 0x22 -> next cycle all busy=0, x2=0x22, x4 not busy.
- Reset mid-operation: x6 busy and written 0x66; assert rst one cycle together with wb x6 -> x6=0, busy=0, and the wb is not committed.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared core parameters for the integer register file and its consumers.
package cpu_pkg;
  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int AW_DEF   = $clog2(NREG_DEF);
  localparam int TAGW_DEF = 4;
  localparam int REG_ZERO = 0;
endpackage

// File: rtl/regfile_sb_rdport.sv
// One read port: x0 masking plus bypass of a same-cycle committing writeback.
module regfile_sb_rdport
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int AW   = AW_DEF,
  parameter int TAGW = TAGW_DEF
) (
  input  logic [AW-1:0]   addr_i,
  input  logic [XLEN-1:0] reg_data_i,
  input  logic            reg_busy_i,
  input  logic [TAGW-1:0] reg_tag_i,
  input  logic            wb_hit_i,
  input  logic [AW-1:0]   wb_addr_i,
  input  logic [XLEN-1:0] wb_data_i,
  output logic [XLEN-1:0] data_o,
  output logic            busy_o,
  output logic [TAGW-1:0] tag_o
);

  // The bypass leaves the tag as stored; it is meaningless once busy drops.
  always_comb begin
    data_o = reg_data_i;
    busy_o = reg_busy_i;
    tag_o  = reg_tag_i;
    if (addr_i == AW'(REG_ZERO)) begin
      data_o = '0;
      busy_o = 1'b0;
      tag_o  = '0;
    end else if (wb_hit_i && (wb_addr_i == addr_i)) begin
      data_o = wb_data_i;
      busy_o = 1'b0;
    end else begin
      data_o = reg_data_i;
    end
  end

endmodule

// File: rtl/regfile_sb.sv
// Multi-read-port register file with a per-register busy/tag scoreboard;
// writebacks commit only when they carry the newest reservation's tag.
module regfile_sb
  import cpu_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int NREG = NREG_DEF,
  parameter int AW   = $clog2(NREG),
  parameter int NRD  = 2,
  parameter int TAGW = TAGW_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  output logic [NRD*TAGW-1:0]  rd_tag,
  input  logic                 iss_en,
  input  logic [AW-1:0]        iss_addr,
  input  logic [TAGW-1:0]      iss_tag,
  input  logic                 wb_en,
  input  logic [AW-1:0]        wb_addr,
  input  logic [TAGW-1:0]      wb_tag,
  input  logic [XLEN-1:0]      wb_data,
  input  logic                 flush
);

  logic [XLEN-1:0] regs_q [NREG];
  logic [XLEN-1:0] regs_d [NREG];
  logic [TAGW-1:0] tag_q  [NREG];
  logic [TAGW-1:0] tag_d  [NREG];
  logic [NREG-1:0] busy_q;
  logic [NREG-1:0] busy_d;
  logic            wb_hit_s;

  assign wb_hit_s = wb_en && (wb_addr != AW'(REG_ZERO)) && busy_q[wb_addr]
                    && (tag_q[wb_addr] == wb_tag);

  // Issue is applied after writeback so a same-register issue wins busy/tag.
  always_comb begin
    regs_d = regs_q;
    busy_d = busy_q;
    tag_d  = tag_q;
    if (wb_hit_s) begin
      regs_d[wb_addr] = wb_data;
      busy_d[wb_addr] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (flush) begin
      busy_d = '0;
    end else if (iss_en && (iss_addr != AW'(REG_ZERO))) begin
      busy_d[iss_addr] = 1'b1;
      tag_d[iss_addr]  = iss_tag;
    end else begin
      tag_d = tag_d;
    end
  end

  // Scoreboard and storage state.
  always_ff @(posedge clk) begin
    if (rst) begin
      regs_q <= '{default: '0};
      tag_q  <= '{default: '0};
      busy_q <= '0;
    end else begin
      regs_q <= regs_d;
      tag_q  <= tag_d;
      busy_q <= busy_d;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    logic [AW-1:0] a_s;
    assign a_s = rd_addr[k*AW +: AW];

    regfile_sb_rdport #(
      .XLEN (XLEN),
      .AW   (AW),
      .TAGW (TAGW)
    ) u_rdport (
      .addr_i     (a_s),
      .reg_data_i (regs_q[a_s]),
      .reg_busy_i (busy_q[a_s]),
      .reg_tag_i  (tag_q[a_s]),
      .wb_hit_i   (wb_hit_s),
      .wb_addr_i  (wb_addr),
      .wb_data_i  (wb_data),
      .data_o     (rd_data[k*XLEN +: XLEN]),
      .busy_o     (rd_busy[k]),
      .tag_o      (rd_tag[k*TAGW +: TAGW])
    );
  end

endmodule

// File: tb/tb_regfile_sb.sv
// Directed self-checking bench for regfile_sb with hand-computed expectations.
module tb_regfile_sb;
  localparam int XLEN = 32;
  localparam int AW   = 5;
  localparam int NRD  = 2;
  localparam int TAGW = 4;

  logic                 clk = 1'b0;
  logic                 rst;
  logic [NRD*AW-1:0]    rd_addr;
  logic [NRD*XLEN-1:0]  rd_data;
  logic [NRD-1:0]       rd_busy;
  logic [NRD*TAGW-1:0]  rd_tag;
  logic                 iss_en;
  logic [AW-1:0]        iss_addr;
  logic [TAGW-1:0]      iss_tag;
  logic                 wb_en;
  logic [AW-1:0]        wb_addr;
  logic [TAGW-1:0]      wb_tag;
  logic [XLEN-1:0]      wb_data;
  logic                 flush;

  int checks = 0;
  int errors = 0;

  logic [XLEN-1:0] d0, d1;
  logic [TAGW-1:0] t0, t1;
  logic            b0, b1;
  assign d0 = rd_data[XLEN-1:0];
  assign d1 = rd_data[2*XLEN-1:XLEN];
  assign t0 = rd_tag[TAGW-1:0];
  assign t1 = rd_tag[2*TAGW-1:TAGW];
  assign b0 = rd_busy[0];
  assign b1 = rd_busy[1];

  always #5 clk = ~clk;

  regfile_sb dut (
    .clk(clk), .rst(rst), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_busy(rd_busy), .rd_tag(rd_tag), .iss_en(iss_en), .iss_addr(iss_addr),
    .iss_tag(iss_tag), .wb_en(wb_en), .wb_addr(wb_addr), .wb_tag(wb_tag),
    .wb_data(wb_data), .flush(flush)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_rd(input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    rd_addr = {a1, a0};
  endtask

  task automatic idle();
    iss_en = 1'b0; wb_en = 1'b0; flush = 1'b0;
  endtask

  task automatic test_reset();
    set_rd(5'd5, 5'd5);
    #1;
    checks++; if (d0 !== 32'h0 || d1 !== 32'h0) begin errors++;
      $display("FAIL reset_data got %h/%h exp 0/0", d0, d1); end
    checks++; if (rd_busy !== 2'b00 || rd_tag !== 8'h00) begin errors++;
      $display("FAIL reset_busy_tag got %b/%h exp 00/00", rd_busy, rd_tag); end
    iss_en = 1'b1; iss_addr = 5'd0; iss_tag = 4'd3;
    tick();
    idle();
    set_rd(5'd0, 5'd0);
    #1;
    checks++; if (b0 !== 1'b0 || d0 !== 32'h0 || t0 !== 4'd0) begin errors++;
      $display("FAIL x0_issue got busy %b data %h tag %h exp 0/0/0", b0, d0, t0); end
  endtask

  task automatic test_issue_wb();
    set_rd(5'd5, 5'd5);
    iss_en = 1'b1; iss_addr = 5'd5; iss_tag = 4'd2;
    #1;
    checks++; if (b0 !== 1'b0) begin errors++;
      $display("FAIL issue_not_same_cycle got busy %b exp 0", b0); end
    tick();
    idle();
    #1;
    checks++; if (b0 !== 1'b1 || t0 !== 4'd2 || b1 !== 1'b1 || t1 !== 4'd2) begin errors++;
      $display("FAIL issue_busy got %b/%h %b/%h exp 1/2 1/2", b0, t0, b1, t1); end
    wb_en = 1'b1; wb_addr = 5'd5; wb_tag = 4'd2; wb_data = 32'hDEADBEEF;
    #1;
    checks++; if (d0 !== 32'hDEADBEEF || b0 !== 1'b0 || d1 !== 32'hDEADBEEF || b1 !== 1'b0) begin
      errors++; $display("FAIL wb_bypass got %h/%b %h/%b exp deadbeef/0", d0, b0, d1, b1); end
    tick();
    idle();
    #1;
    checks++; if (d0 !== 32'hDEADBEEF || b0 !== 1'b0) begin errors++;
      $display("FAIL wb_commit got %h/%b exp deadbeef/0", d0, b0); end
  endtask

  task automatic test_waw();
    set_rd(5'd7, 5'd0);
    iss_en = 1'b1; iss_addr = 5'd7; iss_tag = 4'd1;
    tick();
    iss_tag = 4'd4;
    tick();
    idle();
    wb_en = 1'b1; wb_addr = 5'd7; wb_tag = 4'd1; wb_data = 32'h11;
    #1;
    checks++; if (b0 !== 1'b1 || d0 !== 32'h0) begin errors++;
      $display("FAIL waw_stale_bypass got %b/%h exp 1/0", b0, d0); end
    tick();
    idle();
    #1;
    checks++; if (b0 !== 1'b1 || t0 !== 4'd4 || d0 !== 32'h0) begin errors++;
      $display("FAIL waw_stale_drop got %b/%h/%h exp 1/4/0", b0, t0, d0); end
    wb_en = 1'b1; wb_addr = 5'd7; wb_tag = 4'd4; wb_data = 32'h44;
    tick();
    idle();
    #1;
    checks++; if (d0 !== 32'h44 || b0 !== 1'b0) begin errors++;
      $display("FAIL waw_new_commit got %h/%b exp 44/0", d0, b0); end
  endtask

  task automatic test_simultaneous();
    set_rd(5'd9, 5'd0);
    iss_en = 1'b1; iss_addr = 5'd9; iss_tag = 4'd3;
    tick();
    wb_en = 1'b1; wb_addr = 5'd9; wb_tag = 4'd3; wb_data = 32'h99;
    iss_tag = 4'd5;
    tick();
    idle();
    #1;
    checks++; if (d0 !== 32'h99 || b0 !== 1'b1 || t0 !== 4'd5) begin errors++;
      $display("FAIL simul_iss_wb got %h/%b/%h exp 99/1/5", d0, b0, t0); end
  endtask

  task automatic test_flush();
    iss_en = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      iss_addr = AW'(i); iss_tag = TAGW'(i);
      tick();
    end
    flush = 1'b1; iss_addr = 5'd4; iss_tag = 4'd6;
    wb_en = 1'b1; wb_addr = 5'd2; wb_tag = 4'd2; wb_data = 32'h22;
    tick();
    idle();
    set_rd(5'd1, 5'd2);
    #1;
    checks++; if (b0 !== 1'b0 || b1 !== 1'b0 || d1 !== 32'h22) begin errors++;
      $display("FAIL flush_x1_x2 got %b %b/%h exp 0 0/22", b0, b1, d1); end
    set_rd(5'd3, 5'd4);
    #1;
    checks++; if (b0 !== 1'b0 || b1 !== 1'b0 || d0 !== 32'h0) begin errors++;
      $display("FAIL flush_x3_x4 got %b/%h %b exp 0/0 0", b0, d0, b1); end
  endtask

  task automatic test_reset_mid();
    set_rd(5'd6, 5'd0);
    iss_en = 1'b1; iss_addr = 5'd6; iss_tag = 4'd7;
    tick();
    idle();
    wb_en = 1'b1; wb_addr = 5'd6; wb_tag = 4'd7; wb_data = 32'h66;
    tick();
    idle();
    iss_en = 1'b1; iss_addr = 5'd6; iss_tag = 4'd8;
    tick();
    idle();
    #1;
    checks++; if (d0 !== 32'h66 || b0 !== 1'b1 || t0 !== 4'd8) begin errors++;
      $display("FAIL pre_reset got %h/%b/%h exp 66/1/8", d0, b0, t0); end
    rst = 1'b1;
    wb_en = 1'b1; wb_addr = 5'd6; wb_tag = 4'd8; wb_data = 32'hAB;
    tick();
    rst = 1'b0;
    idle();
    #1;
    checks++; if (d0 !== 32'h0 || b0 !== 1'b0 || t0 !== 4'd0) begin errors++;
      $display("FAIL mid_reset got %h/%b/%h exp 0/0/0", d0, b0, t0); end
    wb_en = 1'b1; wb_addr = 5'd6; wb_tag = 4'd0; wb_data = 32'hCC;
    tick();
    idle();
    #1;
    checks++; if (d0 !== 32'h0) begin errors++;
      $display("FAIL wb_non_busy got %h exp 0", d0); end
  endtask

  initial begin
    rst = 1'b1;
    rd_addr = '0; iss_addr = '0; iss_tag = '0;
    wb_addr = '0; wb_tag = '0; wb_data = '0;
    idle();
    tick();
    tick();
    rst = 1'b0;
    test_reset();
    test_issue_wb();
    test_waw();
    test_simultaneous();
    test_flush();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
